// File: rtl/sum_product_accumulator_if.sv
// Sample/result bus of the sum/product accumulator: one upstream sample port
// and one downstream result port. The master side drives samples.
interface sum_product_accumulator_if #(
    parameter int ACC_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [8:0]       in_sum;
    logic [15:0]      in_product;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [8:0]       out_max_sum;
    logic             out_ovf;

    modport master (
        output in_valid, in_sum, in_product, out_ready,
        input  in_ready, out_valid, out_acc, out_max_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, in_product, out_ready,
        output in_ready, out_valid, out_acc, out_max_sum, out_ovf
    );
endinterface

// File: rtl/sum_product_accumulator.sv
// Accumulates products and tracks the largest sum over a window of N_SAMPLES.
// Define SPA_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module sum_product_accumulator #(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    sum_product_accumulator_if.slave   io,
    output logic                       dbg_state
);

    // Valid/ready: a transfer happens on a rising edge where valid && ready are
    // both high; valid may drop at any time, and in_ready depends only on state.
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(N_SAMPLES - 1);

    state_t           state;
    state_t           state_n;

    logic [ACC_W-1:0] acc;
    logic [8:0]       max_sum;
    logic [7:0]       cnt;
    logic             ovf;

    logic [ACC_W-1:0] out_acc_r;
    logic [8:0]       out_max_r;
    logic             out_ovf_r;
    logic             out_valid_r;

    logic             accept;
    logic             last_accept;
    logic             out_hs;
    logic             in_ready_c;

    logic [ACC_W:0]   add_full;
    logic [ACC_W-1:0] acc_upd;
    logic [8:0]       max_upd;
    logic             ovf_upd;

    // FSM next-state and handshake decode
    always_comb begin
        state_n     = state;
        in_ready_c  = 1'b0;
        accept      = 1'b0;
        last_accept = 1'b0;
        out_hs      = 1'b0;
        case (state)
            ACCUM: begin
                in_ready_c = 1'b1;
                accept     = io.in_valid;
                if (io.in_valid && (cnt == LAST_IDX)) begin
                    last_accept = 1'b1;
                    state_n     = HOLD;
                end
            end
            HOLD: begin
                out_hs = out_valid_r && io.out_ready;
                if (out_hs) begin
                    state_n = ACCUM;
                end
            end
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_n;
        end
    end

    // The extra top bit of the add is the carry that marks a window overflow.
    always_comb begin
        add_full = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, io.in_product};
        ovf_upd  = ovf | add_full[ACC_W];
`ifdef SPA_SATURATE_EN
        acc_upd  = ovf_upd ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
        acc_upd  = add_full[ACC_W-1:0];
`endif
        max_upd  = (io.in_sum > max_sum) ? io.in_sum : max_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            max_sum     <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            out_acc_r   <= '0;
            out_max_r   <= '0;
            out_ovf_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (accept) begin
                acc     <= acc_upd;
                max_sum <= max_upd;
                cnt     <= cnt + 8'd1;
                ovf     <= ovf_upd;
            end
            if (last_accept) begin
                out_acc_r   <= acc_upd;
                out_max_r   <= max_upd;
                out_ovf_r   <= ovf_upd;
                out_valid_r <= 1'b1;
            end
            // Result taken: the window state restarts from zero.
            if (out_hs) begin
                out_valid_r <= 1'b0;
                acc         <= '0;
                max_sum     <= '0;
                cnt         <= '0;
                ovf         <= 1'b0;
            end
        end
    end

    assign io.in_ready    = in_ready_c;
    assign io.out_valid   = out_valid_r;
    assign io.out_acc     = out_acc_r;
    assign io.out_max_sum = out_max_r;
    assign io.out_ovf     = out_ovf_r;
    assign dbg_state      = state;

endmodule

// File: tb/tb_sum_product_accumulator.sv
// Directed bench for sum_product_accumulator: default, 16-bit overflow and
// single-sample-window instances.
module tb_sum_product_accumulator;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic dbg_a;
    logic dbg_b;
    logic dbg_c;

    sum_product_accumulator_if #(.ACC_W(24)) ifa ();
    sum_product_accumulator_if #(.ACC_W(16)) ifb ();
    sum_product_accumulator_if #(.ACC_W(24)) ifc ();

    sum_product_accumulator #(.N_SAMPLES(4), .ACC_W(24)) dut_a (
        .clk(clk), .rst(rst), .io(ifa.slave), .dbg_state(dbg_a)
    );
    sum_product_accumulator #(.N_SAMPLES(4), .ACC_W(16)) dut_b (
        .clk(clk), .rst(rst), .io(ifb.slave), .dbg_state(dbg_b)
    );
    sum_product_accumulator #(.N_SAMPLES(1), .ACC_W(24)) dut_c (
        .clk(clk), .rst(rst), .io(ifc.slave), .dbg_state(dbg_c)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [8:0] s, input logic [15:0] p);
        ifa.in_valid   = 1'b1;
        ifa.in_sum     = s;
        ifa.in_product = p;
        tick();
        ifa.in_valid   = 1'b0;
    endtask

    task automatic send_b(input logic [8:0] s, input logic [15:0] p);
        ifb.in_valid   = 1'b1;
        ifb.in_sum     = s;
        ifb.in_product = p;
        tick();
        ifb.in_valid   = 1'b0;
    endtask

    task automatic send_basic_a();
        send_a(9'd109, 16'd990);
        send_a(9'd43,  16'd330);
        send_a(9'd165, 16'd4356);
        send_a(9'd136, 16'd528);
    endtask

    task automatic check_a_result(input string tag, input logic [31:0] acc,
                                  input logic [31:0] mx, input logic [31:0] ov);
        check({tag, "_valid"}, 32'(ifa.out_valid), 32'd1);
        check({tag, "_acc"},   32'(ifa.out_acc), acc);
        check({tag, "_max"},   32'(ifa.out_max_sum), mx);
        check({tag, "_ovf"},   32'(ifa.out_ovf), ov);
        check({tag, "_rdy"},   32'(ifa.in_ready), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_sum = '0; ifa.in_product = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_sum = '0; ifb.in_product = '0; ifb.out_ready = 1'b1;
        ifc.in_valid = 1'b0; ifc.in_sum = '0; ifc.in_product = '0; ifc.out_ready = 1'b1;

        // reset values
        repeat (2) tick();
        check("rst_rdy_a",   32'(ifa.in_ready), 32'd1);
        check("rst_valid_a", 32'(ifa.out_valid), 32'd0);
        check("rst_acc_a",   32'(ifa.out_acc), 32'd0);
        check("rst_max_a",   32'(ifa.out_max_sum), 32'd0);
        check("rst_ovf_a",   32'(ifa.out_ovf), 32'd0);
        check("rst_dbg_a",   32'(dbg_a), 32'd0);
        check("rst_rdy_b",   32'(ifb.in_ready), 32'd1);
        check("rst_rdy_c",   32'(ifc.in_ready), 32'd1);
        rst = 1'b0;
        tick();

        // reset mid-window discards the two partial samples
        send_a(9'd200, 16'd2000);
        send_a(9'd250, 16'd3000);
        rst = 1'b1;
        #2;
        check("midrst_valid", 32'(ifa.out_valid), 32'd0);
        check("midrst_acc",   32'(ifa.out_acc), 32'd0);
        check("midrst_rdy",   32'(ifa.in_ready), 32'd1);
        tick();
        rst = 1'b0;

        // basic window, out_ready = 1
        send_a(9'd109, 16'd990);
        send_a(9'd43,  16'd330);
        send_a(9'd165, 16'd4356);
        check("basic_notyet", 32'(ifa.out_valid), 32'd0);
        send_a(9'd136, 16'd528);
        check_a_result("basic", 32'd6204, 32'd165, 32'd0);
        check("basic_dbg", 32'(dbg_a), 32'd1);
        tick();
        check("basic_valid_drop", 32'(ifa.out_valid), 32'd0);
        check("basic_rdy_back",   32'(ifa.in_ready), 32'd1);

        // back-pressure: result held, offered sample refused while in HOLD
        ifa.out_ready = 1'b0;
        send_basic_a();
        ifa.in_valid   = 1'b1;
        ifa.in_sum     = 9'd137;
        ifa.in_product = 16'd660;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_a_result("bp_hold", 32'd6204, 32'd165, 32'd0);
        end
        ifa.out_ready = 1'b1;
        tick();
        check("bp_hs_valid", 32'(ifa.out_valid), 32'd0);
        check("bp_hs_rdy",   32'(ifa.in_ready), 32'd1);
        tick();
        ifa.in_valid = 1'b0;
        send_a(9'd10, 16'd1);
        send_a(9'd20, 16'd2);
        send_a(9'd30, 16'd3);
        check_a_result("bp_next", 32'd666, 32'd137, 32'd0);
        tick();

        // gapped input, in_valid toggling
        send_a(9'd109, 16'd990);  tick();
        send_a(9'd43,  16'd330);  tick();
        send_a(9'd165, 16'd4356); tick();
        check("gap_notyet", 32'(ifa.out_valid), 32'd0);
        send_a(9'd136, 16'd528);
        check_a_result("gap", 32'd6204, 32'd165, 32'd0);
        tick();

        // reset while a result is pending in HOLD
        ifa.out_ready = 1'b0;
        send_basic_a();
        check("hrst_pre", 32'(ifa.out_valid), 32'd1);
        rst = 1'b1;
        #2;
        check("hrst_valid", 32'(ifa.out_valid), 32'd0);
        check("hrst_acc",   32'(ifa.out_acc), 32'd0);
        check("hrst_max",   32'(ifa.out_max_sum), 32'd0);
        check("hrst_rdy",   32'(ifa.in_ready), 32'd1);
        tick();
        rst = 1'b0;
        ifa.out_ready = 1'b1;

        // overflow at ACC_W = 16
        for (int i = 0; i < 4; i++) send_b(9'd510, 16'd65025);
        check("ovf_valid", 32'(ifb.out_valid), 32'd1);
`ifdef SPA_SATURATE_EN
        check("ovf_acc", 32'(ifb.out_acc), 32'd65535);
`else
        check("ovf_acc", 32'(ifb.out_acc), 32'd63492);
`endif
        check("ovf_flag", 32'(ifb.out_ovf), 32'd1);
        check("ovf_max",  32'(ifb.out_max_sum), 32'd510);
        tick();
        for (int i = 0; i < 4; i++) send_b(9'd1, 16'd1);
        check("ovf_clr_acc",  32'(ifb.out_acc), 32'd4);
        check("ovf_clr_flag", 32'(ifb.out_ovf), 32'd0);
        check("ovf_clr_max",  32'(ifb.out_max_sum), 32'd1);
        tick();

        // single-sample window
        ifc.in_valid   = 1'b1;
        ifc.in_sum     = 9'd43;
        ifc.in_product = 16'd330;
        tick();
        check("n1_a_valid", 32'(ifc.out_valid), 32'd1);
        check("n1_a_acc",   32'(ifc.out_acc), 32'd330);
        check("n1_a_max",   32'(ifc.out_max_sum), 32'd43);
        check("n1_a_rdy",   32'(ifc.in_ready), 32'd0);
        ifc.in_sum     = 9'd165;
        ifc.in_product = 16'd4356;
        tick();
        check("n1_gap_valid", 32'(ifc.out_valid), 32'd0);
        check("n1_gap_rdy",   32'(ifc.in_ready), 32'd1);
        tick();
        ifc.in_valid = 1'b0;
        check("n1_b_valid", 32'(ifc.out_valid), 32'd1);
        check("n1_b_acc",   32'(ifc.out_acc), 32'd4356);
        check("n1_b_max",   32'(ifc.out_max_sum), 32'd165);
        check("n1_b_rdy",   32'(ifc.in_ready), 32'd0);
        tick();
        check("n1_end_valid", 32'(ifc.out_valid), 32'd0);
        check("n1_end_rdy",   32'(ifc.in_ready), 32'd1);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_product_accumulator.md
# sum_product_accumulator

Downstream consumer of the sum/product arithmetic stage. Accepts one {sum, product} sample per handshake, accumulates products over a fixed window of N_SAMPLES, tracks the largest sum in the window, and presents the window result on a valid/ready output port. Sits between the 8-bit operand arithmetic (9-bit sum, 16-bit product) and any reporting or monitor logic.

## Interface
- N_SAMPLES, 4, samples per window; legal range 1..255
- ACC_W, 24, accumulator width; must be ≥ 16

- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream sample valid
- in_ready  out  1  block can accept a sample
- in_sum  in  9  unsigned sum of the two operands
- in_product  in  16  unsigned product of the two operands
- out_valid  out  1  window result valid
- out_ready  in  1  downstream accepts the result
- out_acc  out  ACC_W  sum of products over the window
- out_max_sum  out  9  largest in_sum seen in the window
- out_ovf  out  1  accumulator exceeded 2^ACC_W−1 during the window

## Operation
- Two states: ACCUM and HOLD. Reset state is ACCUM.
- ACCUM:
  - in_ready = 1.
  - Sample accepted when in_valid && in_ready at a rising edge.
  - On accept: acc ← acc + zero-extended in_product; max ← max(max, in_sum); cnt ← cnt + 1.
  - Accept with cnt == N_SAMPLES−1: the updated acc, max, and ovf are copied to the output registers, out_valid ← 1, and the state moves to HOLD.
- HOLD:
  - in_ready = 0; out_* held stable.
  - On out_valid && out_ready: out_valid ← 0; acc, max, cnt, and internal ovf clear to 0; state moves to ACCUM.
- Arithmetic:
  - Addition is computed at ACC_W+1 bits. A carry out sets the sticky ovf for the current window.
  - Default behaviour: acc keeps the low ACC_W bits (wraps).
  - max compare is unsigned, 9-bit. Ties leave max unchanged.
- in_sum and in_product are ignored when in_valid is low or when in_ready is low.
- in_valid is not required to stay asserted; the block imposes no stability rule on upstream.

## Timing
- Reset values: in_ready = 1 (combinational from state), out_valid = 0, out_acc = 0, out_max_sum = 0, out_ovf = 0. acc, max, cnt, and ovf all clear to 0.
- Reset is asynchronous. Asserting rst during ACCUM or HOLD discards the partial window and any pending result immediately.
- Throughput in ACCUM: one sample per cycle.
- Latency: out_valid rises at the same edge that accepts the N_SAMPLES-th sample. Results are visible in the following cycle.
- Back-pressure: the minimum HOLD duration is 1 cycle. in_ready returns to 1 the cycle after the output handshake. No sample is accepted in the handshake cycle.
- out_ready while out_valid = 0 has no effect.
- N_SAMPLES = 1: every accepted sample produces a result and enters HOLD.
- cnt is 8 bits and never wraps, because it clears on each output handshake.

## Configuration
- SPA_SATURATE_EN:
  - Defined: on an overflowing add, acc clamps to 2^ACC_W−1 and stays there for the rest of the window. out_ovf is still reported.
  - Undefined: acc wraps modulo 2^ACC_W, and out_ovf reports the wrap.

## Test plan
- Reset mid-window: rst is asserted after 2 accepts, then released. The next 4 samples produce a result that reflects only those 4 samples. All outputs read 0 while rst is high.
- Basic window, N_SAMPLES=4, out_ready=1:
  - Stimulus: samples (109,990), (43,330), (165,4356), (136,528) on consecutive cycles.
  - Required response: out_acc=6204, out_max_sum=165, out_ovf=0, out_valid high for 1 cycle.
  - in_ready low for exactly 1 cycle.
- Back-pressure:
  - Stimulus: same 4 samples with out_ready held 0 for 5 cycles; (137,660) is offered during HOLD.
  - Required response: outputs stable, in_ready=0, and (137,660) is not accepted until the handshake completes.
  - The next window starts with acc=660 after its accept.
- Gapped input: in_valid toggles 1,0,1,0,… with the same 4 samples. The result is identical to the basic window test and appears after the 4th accept.
- Overflow, ACC_W=16, 4 × (510,65025):
  - Without SPA_SATURATE_EN: out_acc=63492, out_ovf=1.
  - With SPA_SATURATE_EN: out_acc=65535, out_ovf=1.
  - out_max_sum=510 in both cases.
- N_SAMPLES=1: samples (43,330) then (165,4356) with out_ready=1. Two results are produced: 330/43 and 4356/165, with a 1-cycle in_ready gap after each.
